// File: rtl/riscv_rf_pkg.sv
// Shared sizes and types for the RV32I integer register file.
// Imported by the register file top and its read-select sub-module.
package riscv_rf_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t X0 = 5'd0;

endpackage : riscv_rf_pkg

// File: rtl/rf_read_mux.sv
// One architectural read: x0 forces zero, a same-cycle write to the same
// index is forwarded, otherwise the stored value is returned.
module rf_read_mux
  import riscv_rf_pkg::*;
#(
  parameter int RF_XLEN  = XLEN,
  parameter int RF_NREGS = NREGS
) (
  input  logic [REG_ADDR_W-1:0]                rd_addr_i,
  input  logic                                 wr_en_i,
  input  logic [REG_ADDR_W-1:0]                wr_addr_i,
  input  logic [RF_XLEN-1:0]                   wr_data_i,
  input  logic [RF_NREGS-1:0][RF_XLEN-1:0]     rf_i,
  output logic [RF_XLEN-1:0]                   rd_data_o
);

  logic is_x0;
  logic in_range;
  logic bypass_hit;

  assign is_x0      = (rd_addr_i == X0);
  assign in_range   = (int'(rd_addr_i) < RF_NREGS);
  assign bypass_hit = wr_en_i && (wr_addr_i == rd_addr_i);

  // Priority matters: x0 must stay zero even when a write targets it.
  always_comb begin
    rd_data_o = '0;
    if (is_x0 || !in_range) begin
      rd_data_o = '0;
    end else if (bypass_hit) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = rf_i[rd_addr_i];
    end
  end

endmodule : rf_read_mux

// File: rtl/reg_file_2r1w.sv
// RV32I integer register file: 31 stored registers plus hardwired x0,
// two combinational read ports with write bypass and a registered debug port.
module reg_file_2r1w
  import riscv_rf_pkg::*;
#(
  parameter int XLEN  = riscv_rf_pkg::XLEN,
  parameter int NREGS = riscv_rf_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]       rs1_data,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_data
);

  // Debug handshake: dbg_req/dbg_addr are sampled on every rising edge with
  // no backpressure; each sampled request yields dbg_ack=1 for exactly the
  // following cycle with dbg_data valid alongside it. Without a request,
  // dbg_ack is 0 and dbg_data keeps the last captured value.

  logic [XLEN-1:0]              regs_q [1:NREGS-1];
  logic [NREGS-1:0][XLEN-1:0]   rf_view;
  logic                         wr_commit;

  logic [XLEN-1:0]              rs1_rd;
  logic [XLEN-1:0]              rs2_rd;
  logic [XLEN-1:0]              dbg_rd;

  logic                         dbg_ack_d;
  logic                         dbg_ack_q;
  logic [XLEN-1:0]              dbg_data_d;
  logic [XLEN-1:0]              dbg_data_q;

  assign wr_commit = wr_en && (wr_addr != X0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Flat view with slot 0 tied low so the read muxes see a uniform array.
  always_comb begin
    rf_view    = '0;
    for (int i = 1; i < NREGS; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  rf_read_mux #(
    .RF_XLEN  (XLEN),
    .RF_NREGS (NREGS)
  ) u_rs1_mux (
    .rd_addr_i (rs1_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rf_i      (rf_view),
    .rd_data_o (rs1_rd)
  );

  rf_read_mux #(
    .RF_XLEN  (XLEN),
    .RF_NREGS (NREGS)
  ) u_rs2_mux (
    .rd_addr_i (rs2_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rf_i      (rf_view),
    .rd_data_o (rs2_rd)
  );

  rf_read_mux #(
    .RF_XLEN  (XLEN),
    .RF_NREGS (NREGS)
  ) u_dbg_mux (
    .rd_addr_i (dbg_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rf_i      (rf_view),
    .rd_data_o (dbg_rd)
  );

  // During reset the bypass path could leak wr_data, so reads are forced to 0.
  assign rs1_data = resetn ? rs1_rd : '0;
  assign rs2_data = resetn ? rs2_rd : '0;

  always_comb begin
    dbg_ack_d  = dbg_req;
    dbg_data_d = dbg_data_q;
    if (dbg_req) begin
      dbg_data_d = dbg_rd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios followed by a
// randomized phase, with a reference register model and expected queues.
module tb_reg_file_2r1w;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [4:0]   rs1_addr;
  logic [W-1:0] rs1_data;
  logic [4:0]   rs2_addr;
  logic [W-1:0] rs2_data;
  logic         dbg_req;
  logic [4:0]   dbg_addr;
  logic         dbg_ack;
  logic [W-1:0] dbg_data;

  logic [W-1:0] model [32];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] dbg_q [$];
  logic [W-1:0] dbg_last;

  int n_vec;
  int n_err;

  reg_file_2r1w dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_rd(input logic [4:0] a);
    if (!resetn) return '0;
    if (a == 5'd0) return '0;
    if (wr_en && (wr_addr == a)) return wr_data;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    dbg_q.delete();
    exp_q.delete();
    dbg_last = '0;
  endtask

  // Drives both read addresses, queues the expected data, then checks it.
  task automatic read_check(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    exp_q.push_back(model_rd(a1));
    exp_q.push_back(model_rd(a2));
    #1;
    check("rs1_data", rs1_data, exp_q.pop_front());
    check("rs2_data", rs2_data, exp_q.pop_front());
  endtask

  // One functional clock edge with debug and write tracking.
  task automatic tick();
    logic exp_ack;
    exp_ack = dbg_req && resetn;
    if (exp_ack) dbg_q.push_back(model_rd(dbg_addr));
    @(posedge clk);
    if (resetn && wr_en && (wr_addr != 5'd0)) model[wr_addr] = wr_data;
    #1;
    check("dbg_ack", {31'b0, dbg_ack}, {31'b0, exp_ack});
    if (exp_ack) begin
      if (dbg_q.size() == 0) begin
        check("dbg_queue_empty", 32'd1, 32'd0);
      end else begin
        dbg_last = dbg_q.pop_front();
        check("dbg_data", dbg_data, dbg_last);
      end
    end else begin
      check("dbg_hold", dbg_data, dbg_last);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    resetn   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    dbg_req  = 1'b0;
    dbg_addr = '0;
    model_clear();

    // Reset state; a write held during reset must neither show nor land.
    repeat (2) @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hCAFEF00D;
    for (int i = 0; i < 32; i++) read_check(5'(i), 5'(31 - i));
    check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    check("rst_dbg_data", dbg_data, 32'd0);
    @(negedge clk);
    wr_en  = 1'b0;
    resetn = 1'b1;
    read_check(5'd3, 5'd3);

    // Plain write then read.
    write_reg(5'd5, 32'hDEADBEEF);
    read_check(5'd5, 5'd5);
    read_check(5'd6, 5'd5);

    // Writes to x0 are dropped and never bypassed.
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h12345678;
    dbg_req  = 1'b1;
    dbg_addr = 5'd0;
    read_check(5'd0, 5'd0);
    tick();
    wr_en   = 1'b0;
    dbg_req = 1'b0;
    read_check(5'd0, 5'd0);
    tick();

    // Same-cycle bypass on both ports and the debug capture.
    write_reg(5'd7, 32'h00000001);
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'hA5A5A5A5;
    dbg_req  = 1'b1;
    dbg_addr = 5'd7;
    read_check(5'd7, 5'd7);
    tick();
    wr_en   = 1'b0;
    dbg_req = 1'b0;
    read_check(5'd7, 5'd7);

    // Back-to-back debug requests.
    write_reg(5'd1, 32'd1);
    write_reg(5'd2, 32'd2);
    write_reg(5'd3, 32'd3);
    dbg_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dbg_addr = 5'(i);
      tick();
    end
    dbg_req = 1'b0;
    tick();

    // Asynchronous reset with a request pending.
    write_reg(5'd9, 32'hFFFF0000);
    dbg_req  = 1'b1;
    dbg_addr = 5'd9;
    tick();
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    check("async_rst_ack", {31'b0, dbg_ack}, 32'd0);
    check("async_rst_data", dbg_data, 32'd0);
    read_check(5'd9, 5'd9);
    @(posedge clk);
    #1;
    check("rst_req_no_ack", {31'b0, dbg_ack}, 32'd0);
    dbg_req = 1'b0;
    resetn  = 1'b1;
    read_check(5'd9, 5'd9);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      dbg_req  = 1'($urandom_range(0, 1));
      dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) read_check(wr_addr, 5'($urandom_range(0, 31)));
      else read_check(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end
    wr_en   = 1'b0;
    dbg_req = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) read_check(5'(i), 5'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_2r1w
